lvds_iq_deframer: RTL and testbench
===================================

Name: lvds_iq_deframer

Overview:
- Parametrised successor to the I/Q DDR receive deframer.
- Sits between the 2-bit DDR LVDS capture and the RX sample FIFO.
- Rebuilds I/Q frames of generic sample width and checks both sync symbols.
- Requires a configurable number of consecutive good frames before it pushes anything, and reports sync errors and FIFO-full drops in saturating counters.

Parameters:
- DATA_W, 13: payload bits per I or Q half. Must be odd so each half is a whole number of dibits.
- I_SYNC, 2'b10: sync symbol that opens the I half.
- Q_SYNC, 2'b01: sync symbol that opens the Q half.
- LOCK_COUNT, 4: consecutive good frames needed to lock. 0 means always locked.
- CTRL_MODE, 0: 0 passes the Q control bit through. 1 replaces it with the captured i_sync_input.
- CNT_W, 16: width of the error and drop counters.
- Derived, not overridable:
  - HALF_W = DATA_W+3 (sync + data + ctrl).
  - FRAME_W = 2*HALF_W (32 by default).
  - HALF_D = HALF_W/2 dibits (8 by default).

Ports:
- i_ddr_clk  in  1  DDR-domain clock, one dibit per rising edge; the only clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_ddr_data  in  2  deserialised dibit, first-received bit in [1].
- i_sync_input  in  1  external timing mark, sampled with each frame.
- i_fifo_full  in  1  sample FIFO full flag.
- i_clear_counters  in  1  synchronous clear of both counters.
- o_fifo_write_clk  out  1  equal to i_ddr_clk.
- o_fifo_push  out  1  one-cycle write strobe.
- o_fifo_data  out  FRAME_W  {I_SYNC, I data, I ctrl, Q_SYNC, Q data, Q ctrl}, MSB first in time.
- o_locked  out  1  lock status.
- o_sync_err_count  out  CNT_W  saturating sync-error counter.
- o_drop_count  out  CNT_W  saturating count of frames lost to FIFO full.
- o_debug_state  out  2  FSM state.

Behaviour:
- Reset (asynchronous, i_rst=1):
  - State HUNT; o_fifo_push=0; o_fifo_data=0; o_locked=0.
  - Both counters = 0; good-frame counter = 0; dibit index = 0.
  - Reset mid-frame discards the partial frame. The first edge after reset release is evaluated in HUNT.
- Frame structure, counted by dibit index k = 0..2*HALF_D-1:
  - k=0 is I_SYNC; k=HALF_D is Q_SYNC.
  - All dibits shift into a FRAME_W assembly register, MSB first.
- FSM states, o_debug_state encoding: HUNT=00, I_HALF=01, Q_HALF=11.
  - HUNT, dibit == I_SYNC: load it as k=0, sample i_sync_input, go to I_HALF.
  - HUNT, dibit != I_SYNC while o_locked=1: increment sync errors, clear lock and good-frame counter, stay in HUNT.
  - HUNT, dibit != I_SYNC while unlocked: skip silently.
  - I_HALF: shift dibits k=1..HALF_D-1. At k=HALF_D:
    - dibit == Q_SYNC: go to Q_HALF.
    - Otherwise: increment sync errors, clear lock and good-frame counter, go to HUNT.
    - The mismatched dibit is not re-evaluated as an I_SYNC candidate.
  - Q_HALF: shift dibits up to k=2*HALF_D-1. On the last dibit the frame is complete and the FSM goes to HUNT.
  - Back-to-back frames: the next I_SYNC is accepted on the very next edge, so there are no gap cycles.
- Frame completion:
  - Increment the good-frame counter, saturating at LOCK_COUNT.
  - Set lock when the counter reaches LOCK_COUNT. The frame that achieves lock counts as locked.
  - If CTRL_MODE=1, bit 0 of the frame is replaced by the i_sync_input value captured at k=0.
- Push rules:
  - If locked after the update and i_fifo_full=0: register the frame into o_fifo_data and pulse o_fifo_push on the next edge.
  - Latency is one cycle after the last dibit's edge.
  - If locked and i_fifo_full=1: no push, o_fifo_data unchanged, drop count increments.
  - If unlocked: no push, no drop count.
- o_fifo_data holds its value between pushes. o_fifo_push is never high on two consecutive cycles.
- Counters:
  - Saturate at 2^CNT_W-1.
  - i_clear_counters clears both to 0. Clear wins over a same-cycle increment.
- LOCK_COUNT=0: o_locked is forced to 1 from reset release, and sync errors never clear it.

Test Plan:
- Stream 6 valid default frames (I data 13'h1ABC, Q data 13'h0123, ctrl 0/1), LOCK_COUNT=4 -> no push for frames 1-3; push pulses for frames 4-6, each one cycle after the 16th dibit; o_fifo_data = {2'b10,13'h1ABC,1'b0,2'b01,13'h0123,1'b1}.
- Locked stream; corrupt the Q_SYNC of frame 7 to 2'b11 -> o_sync_err_count=1, o_locked drops the next cycle; 4 further good frames needed before the next push.
- Locked; hold i_fifo_full=1 across 3 frames -> no pushes, o_drop_count=3, o_fifo_data unchanged; release -> the next frame is pushed normally.
- CTRL_MODE=1; i_sync_input=1 only at k=0 of frame 5 -> that frame's bit 0 = 1, all other frames' bit 0 = 0, regardless of the transmitted Q ctrl bit.
- Assert i_rst for 1 cycle at dibit k=10 of a locked stream -> all outputs 0, HUNT; the frame after release needs a fresh 4-frame lock.
- CNT_W=2; inject 5 sync errors, then assert i_clear_counters together with a 6th error -> count sticks at 3, then reads 0.

Source files
------------

// File: rtl/lvds_iq_deframer.sv
// I/Q DDR receive deframer: rebuilds sync-delimited I/Q frames from a dibit stream,
// gates FIFO pushes behind a good-frame lock, and counts sync errors and FIFO-full drops.
module lvds_iq_deframer #(
  parameter int          DATA_W     = 13,
  parameter logic [1:0]  I_SYNC     = 2'b10,
  parameter logic [1:0]  Q_SYNC     = 2'b01,
  parameter int          LOCK_COUNT = 4,
  parameter int          CTRL_MODE  = 0,
  parameter int          CNT_W      = 16,
  localparam int         HALF_W     = DATA_W + 3,
  localparam int         FRAME_W    = 2 * HALF_W,
  localparam int         HALF_D     = HALF_W / 2
) (
  input  logic               i_ddr_clk,
  input  logic               i_rst,
  input  logic [1:0]         i_ddr_data,
  input  logic               i_sync_input,
  input  logic               i_fifo_full,
  input  logic               i_clear_counters,
  output logic               o_fifo_write_clk,
  output logic               o_fifo_push,
  output logic [FRAME_W-1:0] o_fifo_data,
  output logic               o_locked,
  output logic [CNT_W-1:0]   o_sync_err_count,
  output logic [CNT_W-1:0]   o_drop_count,
  output logic [1:0]         o_debug_state
);

  localparam int             KW            = $clog2(2 * HALF_D);
  localparam logic [KW-1:0]  K_QSYNC       = KW'(HALF_D);
  localparam logic [KW-1:0]  K_LAST        = KW'(2 * HALF_D - 1);
  localparam int             GW            = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);
  localparam logic [GW-1:0]  GOOD_MAX      = GW'(LOCK_COUNT);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic           ALWAYS_LOCKED = (LOCK_COUNT == 0);

  typedef enum logic [1:0] {
    HUNT   = 2'b00,
    I_HALF = 2'b01,
    Q_HALF = 2'b11
  } state_t;

  state_t             state_q, state_d;
  logic [KW-1:0]      k_q, k_d;
  logic [FRAME_W-3:0] asm_q, asm_d;
  logic               cap_q, cap_d;
  logic [GW-1:0]      good_q, good_d;
  logic               locked_q, locked_d;
  logic               push_q, push_d;
  logic [FRAME_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]   err_q, err_d;
  logic [CNT_W-1:0]   drop_q, drop_d;

  logic [FRAME_W-1:0] shifted;
  logic [FRAME_W-1:0] frame;
  logic [GW-1:0]      good_inc;
  logic               err_inc, drop_inc, lose_lock, complete, lock_now;

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    asm_d     = asm_q;
    cap_d     = cap_q;
    good_d    = good_q;
    locked_d  = locked_q | ALWAYS_LOCKED;
    push_d    = 1'b0;
    data_d    = data_q;
    err_inc   = 1'b0;
    drop_inc  = 1'b0;
    lose_lock = 1'b0;
    complete  = 1'b0;
    lock_now  = 1'b0;
    good_inc  = good_q;
    frame     = '0;
    shifted   = {asm_q, i_ddr_data};

    case (state_q)
      HUNT: begin
        if (i_ddr_data == I_SYNC) begin
          asm_d   = shifted[FRAME_W-3:0];
          k_d     = KW'(1);
          cap_d   = i_sync_input;
          state_d = I_HALF;
        end else if (locked_q) begin
          err_inc   = 1'b1;
          lose_lock = 1'b1;
        end
      end
      I_HALF: begin
        if (k_q == K_QSYNC) begin
          if (i_ddr_data == Q_SYNC) begin
            asm_d   = shifted[FRAME_W-3:0];
            k_d     = k_q + KW'(1);
            state_d = Q_HALF;
          end else begin
            // The bad symbol is consumed here, never retried as an I_SYNC candidate.
            err_inc   = 1'b1;
            lose_lock = 1'b1;
            k_d       = '0;
            state_d   = HUNT;
          end
        end else begin
          asm_d = shifted[FRAME_W-3:0];
          k_d   = k_q + KW'(1);
        end
      end
      Q_HALF: begin
        asm_d = shifted[FRAME_W-3:0];
        if (k_q == K_LAST) begin
          complete = 1'b1;
          k_d      = '0;
          state_d  = HUNT;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      default: begin
        k_d     = '0;
        state_d = HUNT;
      end
    endcase

    if (lose_lock) begin
      good_d   = '0;
      locked_d = ALWAYS_LOCKED;
    end

    if (complete) begin
      frame = shifted;
      if (CTRL_MODE == 1) frame[0] = cap_q;
      good_inc = (good_q == GOOD_MAX) ? good_q : good_q + GW'(1);
      good_d   = good_inc;
      // The frame that reaches the threshold is itself treated as locked.
      lock_now = locked_q | ALWAYS_LOCKED | (good_inc == GOOD_MAX);
      locked_d = lock_now;
      if (lock_now) begin
        if (!i_fifo_full) begin
          push_d = 1'b1;
          data_d = frame;
        end else begin
          drop_inc = 1'b1;
        end
      end
    end

    if (i_clear_counters)                     err_d = '0;
    else if (err_inc && (err_q != CNT_MAX))   err_d = err_q + CNT_W'(1);
    else                                      err_d = err_q;

    if (i_clear_counters)                     drop_d = '0;
    else if (drop_inc && (drop_q != CNT_MAX)) drop_d = drop_q + CNT_W'(1);
    else                                      drop_d = drop_q;
  end

  always_ff @(posedge i_ddr_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= HUNT;
      k_q      <= '0;
      asm_q    <= '0;
      cap_q    <= 1'b0;
      good_q   <= '0;
      locked_q <= 1'b0;
      push_q   <= 1'b0;
      data_q   <= '0;
      err_q    <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      asm_q    <= asm_d;
      cap_q    <= cap_d;
      good_q   <= good_d;
      locked_q <= locked_d;
      push_q   <= push_d;
      data_q   <= data_d;
      err_q    <= err_d;
      drop_q   <= drop_d;
    end
  end

  assign o_fifo_write_clk = i_ddr_clk;
  assign o_fifo_push      = push_q;
  assign o_fifo_data      = data_q;
  assign o_locked         = locked_q;
  assign o_sync_err_count = err_q;
  assign o_drop_count     = drop_q;
  assign o_debug_state    = state_q;

endmodule

// File: tb/tb_lvds_iq_deframer.sv
// Bench for lvds_iq_deframer: three instances (default, CTRL_MODE=1, CNT_W=2) fed by
// directed dibit streams; pushes are checked against a scoreboard of expected frames.
module tb_lvds_iq_deframer;

  logic        clk = 1'b0;
  logic [1:0]  ddr     [3];
  logic        sync_in [3];
  logic        full    [3];
  logic        clr     [3];
  logic        rst     [3];
  logic        fwclk   [3];
  logic        push    [3];
  logic [31:0] fdata   [3];
  logic        locked  [3];
  logic [1:0]  dstate  [3];
  logic [15:0] errc    [2];
  logic [15:0] dropc   [2];
  logic [1:0]  errc_c, dropc_c;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  localparam logic [31:0] F_A   = 32'hB578_4247;  // {10,1ABC,0,01,0123,1}
  localparam logic [31:0] F_A0  = 32'hB578_4246;  // same, bit 0 cleared
  localparam logic [31:0] G_A   = 32'h9E1F_6AAA;  // {10,0F0F,1,01,1555,0}

  typedef struct { int u; logic [31:0] data; int cyc; } exp_t;
  exp_t sbq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lvds_iq_deframer dut_a (
    .i_ddr_clk(clk), .i_rst(rst[0]), .i_ddr_data(ddr[0]), .i_sync_input(sync_in[0]),
    .i_fifo_full(full[0]), .i_clear_counters(clr[0]), .o_fifo_write_clk(fwclk[0]),
    .o_fifo_push(push[0]), .o_fifo_data(fdata[0]), .o_locked(locked[0]),
    .o_sync_err_count(errc[0]), .o_drop_count(dropc[0]), .o_debug_state(dstate[0]));

  lvds_iq_deframer #(.CTRL_MODE(1)) dut_b (
    .i_ddr_clk(clk), .i_rst(rst[1]), .i_ddr_data(ddr[1]), .i_sync_input(sync_in[1]),
    .i_fifo_full(full[1]), .i_clear_counters(clr[1]), .o_fifo_write_clk(fwclk[1]),
    .o_fifo_push(push[1]), .o_fifo_data(fdata[1]), .o_locked(locked[1]),
    .o_sync_err_count(errc[1]), .o_drop_count(dropc[1]), .o_debug_state(dstate[1]));

  lvds_iq_deframer #(.CNT_W(2)) dut_c (
    .i_ddr_clk(clk), .i_rst(rst[2]), .i_ddr_data(ddr[2]), .i_sync_input(sync_in[2]),
    .i_fifo_full(full[2]), .i_clear_counters(clr[2]), .o_fifo_write_clk(fwclk[2]),
    .o_fifo_push(push[2]), .o_fifo_data(fdata[2]), .o_locked(locked[2]),
    .o_sync_err_count(errc_c), .o_drop_count(dropc_c), .o_debug_state(dstate[2]));

  function automatic logic [31:0] mkf(input logic [1:0] is, input logic [12:0] id, input logic ic,
                                      input logic [1:0] qs, input logic [12:0] qd, input logic qc);
    return {is, id, ic, qs, qd, qc};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drives n dibits of f MSB first on consecutive cycles; queues the expected push.
  task automatic send_frame(input int u, input logic [31:0] f, input int n, input int sync_k,
                            input logic exp_push, input logic [31:0] exp_data, input int clr_k);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      ddr[u]     = f[31-2*k -: 2];
      sync_in[u] = (k == sync_k);
      clr[u]     = (k == clr_k);
      if (k == n-1 && exp_push) begin
        e.u = u; e.data = exp_data; e.cyc = cyc + 1;
        sbq.push_back(e);
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    for (int u = 0; u < 3; u++) begin
      if (push[u] === 1'b1) begin
        checks++;
        if (sbq.size() == 0 || sbq[0].u != u) begin
          errors++;
          $display("FAIL push_unexpected: inst %0d got data %h, no push expected (cycle %0d)",
                   u, fdata[u], cyc);
        end else begin
          e = sbq.pop_front();
          if (fdata[u] !== e.data || cyc != e.cyc) begin
            errors++;
            $display("FAIL push_data: inst %0d got %h at cycle %0d expected %h at cycle %0d",
                     u, fdata[u], cyc, e.data, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] fa, ga, fa_q0, bad_q;
    fa    = mkf(2'b10, 13'h1ABC, 1'b0, 2'b01, 13'h0123, 1'b1);
    ga    = mkf(2'b10, 13'h0F0F, 1'b1, 2'b01, 13'h1555, 1'b0);
    fa_q0 = mkf(2'b10, 13'h1ABC, 1'b0, 2'b01, 13'h0123, 1'b0);
    bad_q = mkf(2'b10, 13'h1ABC, 1'b0, 2'b11, 13'h0123, 1'b1);
    for (int u = 0; u < 3; u++) begin
      ddr[u] = 2'b00; sync_in[u] = 1'b0; full[u] = 1'b0; clr[u] = 1'b0; rst[u] = 1'b1;
    end
    repeat (2) @(negedge clk);
    chk("rst_push",   push[0],   0);
    chk("rst_data",   fdata[0],  0);
    chk("rst_locked", locked[0], 0);
    chk("rst_err",    errc[0],   0);
    chk("rst_drop",   dropc[0],  0);
    chk("rst_state",  dstate[0], 2'b00);
    chk("wr_clk",     fwclk[0],  clk);
    for (int u = 0; u < 3; u++) rst[u] = 1'b0;

    // Lock acquisition: frames 4..6 pushed, back to back.
    for (int n = 1; n <= 6; n++) begin
      send_frame(0, fa, 16, -1, (n >= 4), F_A, -1);
      @(posedge clk); #1;
      chk("lock_status", locked[0], (n >= 4));
      chk("end_state",   dstate[0], 2'b00);
    end

    // Bad Q_SYNC drops lock; four fresh frames needed.
    send_frame(0, bad_q, 9, -1, 1'b0, 0, -1);
    @(posedge clk); #1;
    chk("qsync_err_cnt", errc[0],   1);
    chk("qsync_unlock",  locked[0], 0);
    chk("qsync_state",   dstate[0], 2'b00);
    for (int n = 1; n <= 4; n++) begin
      send_frame(0, fa, 16, -1, (n == 4), F_A, -1);
      @(posedge clk); #1;
      chk("relock", locked[0], (n == 4));
    end

    // FIFO full across three frames.
    full[0] = 1'b1;
    for (int n = 1; n <= 3; n++) send_frame(0, ga, 16, -1, 1'b0, 0, -1);
    @(posedge clk); #1;
    chk("drop_cnt",  dropc[0], 3);
    chk("full_hold", fdata[0], F_A);
    full[0] = 1'b0;
    send_frame(0, ga, 16, -1, 1'b1, G_A, -1);
    @(posedge clk); #1;
    chk("drop_after", dropc[0], 3);

    // Reset mid-frame at k=10.
    send_frame(0, fa, 10, -1, 1'b0, 0, -1);
    @(posedge clk); #1;
    chk("midframe_state", dstate[0], 2'b11);
    @(negedge clk);
    rst[0] = 1'b1; ddr[0] = 2'b00;
    #1;
    chk("arst_push",   push[0],   0);
    chk("arst_data",   fdata[0],  0);
    chk("arst_locked", locked[0], 0);
    chk("arst_err",    errc[0],   0);
    chk("arst_drop",   dropc[0],  0);
    chk("arst_state",  dstate[0], 2'b00);
    @(negedge clk);
    rst[0] = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      send_frame(0, fa, 16, -1, (n == 4), F_A, -1);
      @(posedge clk); #1;
      chk("post_rst_lock", locked[0], (n == 4));
    end
    @(negedge clk); #2;
    rst[0] = 1'b1;

    // CTRL_MODE=1: bit 0 follows the sync mark captured at k=0 only.
    for (int n = 1; n <= 6; n++) begin
      if (n == 5)      send_frame(1, fa_q0, 16, 0,  1'b1, F_A,  -1);
      else if (n == 6) send_frame(1, fa,    16, 3,  1'b1, F_A0, -1);
      else             send_frame(1, fa,    16, -1, (n == 4), F_A0, -1);
      @(posedge clk); #1;
      chk("ctrl_lock", locked[1], (n >= 4));
    end
    @(negedge clk); #2;
    rst[1] = 1'b1;

    // CNT_W=2: saturation and clear-beats-increment.
    for (int n = 1; n <= 5; n++) begin
      send_frame(2, bad_q, 9, -1, 1'b0, 0, -1);
      @(posedge clk); #1;
      if (n == 2) chk("sat_cnt2", errc_c, 2);
    end
    chk("sat_cnt5", errc_c, 3);
    send_frame(2, bad_q, 9, -1, 1'b0, 0, 8);
    @(posedge clk); #1;
    chk("clr_wins", errc_c, 0);
    send_frame(2, bad_q, 9, -1, 1'b0, 0, -1);
    @(posedge clk); #1;
    chk("cnt_after_clr", errc_c, 1);
    chk("c_drop",        dropc_c, 0);
    chk("c_unlocked",    locked[2], 0);

    repeat (3) @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL missing_push: %0d expected pushes never seen", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
